reg_table: RTL and testbench

Register file and forwarding mux feeding the RF/FWD stage of both execution pipes. Holds 128 × 128-bit SPU registers, accepts stage-7 writebacks from the even and odd pipes, and serves six source operands (ra/rb/rc per pipe). Each operand is resolved against in-flight forwarding stages, then same-cycle writebacks, then the array. Read data is registered; it is the value the pipes see as `ra`, `rb`, `rc`.

---
 rtl/reg_table.sv | 68 ++++++
 tb/tb_reg_table.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_table.sv
// reg_table: 128x128 SPU register file with forwarding-resolved, registered operand reads for both pipes.
module reg_table #(
  parameter int NUM_REGS = 128,
  parameter int WIDTH = 128
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [0:WIDTH-1]            rt_wb_even,
  input  logic [0:WIDTH-1]            rt_wb_odd,
  input  logic [6:0]                  rt_addr_wb_even,
  input  logic [6:0]                  rt_addr_wb_odd,
  input  logic                        reg_write_wb_even,
  input  logic                        reg_write_wb_odd,
  input  logic [6:0][0:WIDTH-1]       fw_wb_even,
  input  logic [6:0][0:WIDTH-1]       fw_wb_odd,
  input  logic [6:0][0:6]             fw_addr_wb_even,
  input  logic [6:0][0:6]             fw_addr_wb_odd,
  input  logic [6:0]                  fw_write_wb_even,
  input  logic [6:0]                  fw_write_wb_odd,
  input  logic [6:0]                  ra_addr_even,
  input  logic [6:0]                  rb_addr_even,
  input  logic [6:0]                  rc_addr_even,
  input  logic [6:0]                  ra_addr_odd,
  input  logic [6:0]                  rb_addr_odd,
  input  logic [6:0]                  rc_addr_odd,
  output logic [0:WIDTH-1]            ra_even,
  output logic [0:WIDTH-1]            rb_even,
  output logic [0:WIDTH-1]            rc_even,
  output logic [0:WIDTH-1]            ra_odd,
  output logic [0:WIDTH-1]            rb_odd,
  output logic [0:WIDTH-1]            rc_odd
);
  logic [0:WIDTH-1] regs [NUM_REGS];
  logic [6:0]       src [6];
  logic [0:WIDTH-1] res [6];
  logic [0:WIDTH-1] q [6];
  logic             unused_ok;
  assign src = '{ra_addr_even, rb_addr_even, rc_addr_even, ra_addr_odd, rb_addr_odd, rc_addr_odd};
  assign unused_ok = ^{fw_wb_even[0], fw_wb_odd[0], fw_addr_wb_even[0], fw_addr_wb_odd[0],
                       fw_write_wb_even[0], fw_write_wb_odd[0]};
  // Lowest priority is applied first so later overrides win: stage 1 odd ends up on top.
  always_comb
    for (int k = 0; k < 6; k++) begin
      res[k] = regs[src[k]];
      if (reg_write_wb_even && rt_addr_wb_even == src[k]) res[k] = rt_wb_even;
      if (reg_write_wb_odd && rt_addr_wb_odd == src[k]) res[k] = rt_wb_odd;
      for (int i = 6; i >= 1; i--) begin
        if (fw_write_wb_even[i] && fw_addr_wb_even[i] == src[k]) res[k] = fw_wb_even[i];
        if (fw_write_wb_odd[i] && fw_addr_wb_odd[i] == src[k]) res[k] = fw_wb_odd[i];
      end
    end
  // Odd write is issued second so it takes the slot on an address collision.
  always_ff @(posedge clk)
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      for (int k = 0; k < 6; k++) q[k] <= '0;
    end else begin
      if (reg_write_wb_even) regs[rt_addr_wb_even] <= rt_wb_even;
      if (reg_write_wb_odd) regs[rt_addr_wb_odd] <= rt_wb_odd;
      q <= res;
    end
  assign ra_even = q[0];
  assign rb_even = q[1];
  assign rc_even = q[2];
  assign ra_odd  = q[3];
  assign rb_odd  = q[4];
  assign rc_odd  = q[5];
endmodule

// File: tb/tb_reg_table.sv
// tb_reg_table: directed and random checks of reg_table against a first-match resolution model.
module tb_reg_table;
  logic clk = 1'b0;
  logic reset;
  logic [0:127] rt_wb_even, rt_wb_odd;
  logic [6:0] rt_addr_wb_even, rt_addr_wb_odd;
  logic reg_write_wb_even, reg_write_wb_odd;
  logic [6:0][0:127] fw_wb_even, fw_wb_odd;
  logic [6:0][0:6] fw_addr_wb_even, fw_addr_wb_odd;
  logic [6:0] fw_write_wb_even, fw_write_wb_odd;
  logic [6:0] ra_addr_even, rb_addr_even, rc_addr_even, ra_addr_odd, rb_addr_odd, rc_addr_odd;
  logic [0:127] ra_even, rb_even, rc_even, ra_odd, rb_odd, rc_odd;
  int checks = 0;
  int errors = 0;
  logic [0:127] mregs [128];
  logic [0:127] expq [6];
  logic mvalid = 1'b0;

  reg_table dut (
    .clk(clk), .reset(reset),
    .rt_wb_even(rt_wb_even), .rt_wb_odd(rt_wb_odd),
    .rt_addr_wb_even(rt_addr_wb_even), .rt_addr_wb_odd(rt_addr_wb_odd),
    .reg_write_wb_even(reg_write_wb_even), .reg_write_wb_odd(reg_write_wb_odd),
    .fw_wb_even(fw_wb_even), .fw_wb_odd(fw_wb_odd),
    .fw_addr_wb_even(fw_addr_wb_even), .fw_addr_wb_odd(fw_addr_wb_odd),
    .fw_write_wb_even(fw_write_wb_even), .fw_write_wb_odd(fw_write_wb_odd),
    .ra_addr_even(ra_addr_even), .rb_addr_even(rb_addr_even), .rc_addr_even(rc_addr_even),
    .ra_addr_odd(ra_addr_odd), .rb_addr_odd(rb_addr_odd), .rc_addr_odd(rc_addr_odd),
    .ra_even(ra_even), .rb_even(rb_even), .rc_even(rc_even),
    .ra_odd(ra_odd), .rb_odd(rb_odd), .rc_odd(rc_odd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [0:127] act, input logic [0:127] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // First match wins: forwarding stages youngest first (odd before even), then odd wb, even wb, array.
  function automatic logic [0:127] resolve(input logic [6:0] a);
    for (int i = 1; i <= 6; i++) begin
      if (fw_write_wb_odd[i] && fw_addr_wb_odd[i] == a) return fw_wb_odd[i];
      if (fw_write_wb_even[i] && fw_addr_wb_even[i] == a) return fw_wb_even[i];
    end
    if (reg_write_wb_odd && rt_addr_wb_odd == a) return rt_wb_odd;
    if (reg_write_wb_even && rt_addr_wb_even == a) return rt_wb_even;
    return mregs[a];
  endfunction

  always @(posedge clk)
    if (reset) begin
      for (int r = 0; r < 128; r++) mregs[r] <= '0;
      for (int k = 0; k < 6; k++) expq[k] <= '0;
      mvalid <= 1'b1;
    end else begin
      expq[0] <= resolve(ra_addr_even);
      expq[1] <= resolve(rb_addr_even);
      expq[2] <= resolve(rc_addr_even);
      expq[3] <= resolve(ra_addr_odd);
      expq[4] <= resolve(rb_addr_odd);
      expq[5] <= resolve(rc_addr_odd);
      if (reg_write_wb_even) mregs[rt_addr_wb_even] <= rt_wb_even;
      if (reg_write_wb_odd) mregs[rt_addr_wb_odd] <= rt_wb_odd;
    end

  always @(negedge clk)
    if (mvalid) begin
      check("m_ra_even", ra_even, expq[0]);
      check("m_rb_even", rb_even, expq[1]);
      check("m_rc_even", rc_even, expq[2]);
      check("m_ra_odd", ra_odd, expq[3]);
      check("m_rb_odd", rb_odd, expq[4]);
      check("m_rc_odd", rc_odd, expq[5]);
    end

  task automatic idle();
    reset = 1'b0;
    rt_wb_even = '0; rt_wb_odd = '0;
    rt_addr_wb_even = '0; rt_addr_wb_odd = '0;
    reg_write_wb_even = 1'b0; reg_write_wb_odd = 1'b0;
    fw_wb_even = '0; fw_wb_odd = '0;
    fw_addr_wb_even = '0; fw_addr_wb_odd = '0;
    fw_write_wb_even = '0; fw_write_wb_odd = '0;
    ra_addr_even = '0; rb_addr_even = '0; rc_addr_even = '0;
    ra_addr_odd = '0; rb_addr_odd = '0; rc_addr_odd = '0;
  endtask

  task automatic all_addr(input logic [6:0] a);
    ra_addr_even = a; rb_addr_even = a; rc_addr_even = a;
    ra_addr_odd = a; rb_addr_odd = a; rc_addr_odd = a;
  endtask

  task automatic check_all(input string name, input logic [0:127] exp);
    check({name, "_ra_even"}, ra_even, exp);
    check({name, "_rb_even"}, rb_even, exp);
    check({name, "_rc_even"}, rc_even, exp);
    check({name, "_ra_odd"}, ra_odd, exp);
    check({name, "_rb_odd"}, rb_odd, exp);
    check({name, "_rc_odd"}, rc_odd, exp);
  endtask

  task automatic wr_even(input logic [6:0] a, input logic [0:127] d);
    reg_write_wb_even = 1'b1; rt_addr_wb_even = a; rt_wb_even = d;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_all("reset", 128'h0);
    // reset discards array contents
    idle();
    wr_even(7'd5, {16{8'hAA}});
    @(negedge clk);
    idle();
    all_addr(7'd5);
    @(negedge clk);
    check_all("r5_written", {16{8'hAA}});
    reset = 1'b1;
    @(negedge clk);
    check_all("r5_in_reset", 128'h0);
    reset = 1'b0;
    @(negedge clk);
    check_all("r5_after_reset", 128'h0);
    // plain write then read two edges later
    idle();
    wr_even(7'd10, 128'h0123456789ABCDEF0123456789ABCDEF);
    @(negedge clk);
    idle();
    @(negedge clk);
    ra_addr_even = 7'd10;
    @(negedge clk);
    check("plain_r10", ra_even, 128'h0123456789ABCDEF0123456789ABCDEF);
    // same-edge writeback bypass
    idle();
    wr_even(7'd20, {16{8'h11}});
    rb_addr_odd = 7'd20;
    @(negedge clk);
    check("bypass_r20", rb_odd, {16{8'h11}});
    // write collision: odd wins both via bypass and in the array
    idle();
    wr_even(7'd30, {16{8'h22}});
    reg_write_wb_odd = 1'b1; rt_addr_wb_odd = 7'd30; rt_wb_odd = {16{8'h33}};
    ra_addr_even = 7'd30;
    @(negedge clk);
    check("collide_bypass", ra_even, {16{8'h33}});
    idle();
    rc_addr_odd = 7'd30;
    @(negedge clk);
    check("collide_array", rc_odd, {16{8'h33}});
    // forwarding priority on r40
    idle();
    wr_even(7'd40, {16{8'h44}});
    @(negedge clk);
    idle();
    wr_even(7'd40, {16{8'h77}});
    fw_write_wb_even[6] = 1'b1; fw_addr_wb_even[6] = 7'd40; fw_wb_even[6] = {16{8'h66}};
    fw_write_wb_even[2] = 1'b1; fw_addr_wb_even[2] = 7'd40; fw_wb_even[2] = {16{8'h22}};
    fw_write_wb_odd[2] = 1'b1; fw_addr_wb_odd[2] = 7'd40; fw_wb_odd[2] = {16{8'h99}};
    rc_addr_even = 7'd40;
    @(negedge clk);
    check("fw_odd2", rc_even, {16{8'h99}});
    fw_write_wb_odd[2] = 1'b0;
    @(negedge clk);
    check("fw_even2", rc_even, {16{8'h22}});
    fw_write_wb_even[2] = 1'b0;
    @(negedge clk);
    check("fw_even6", rc_even, {16{8'h66}});
    fw_write_wb_even = '0;
    wr_even(7'd40, {16{8'h78}});
    @(negedge clk);
    check("fw_none_wb", rc_even, {16{8'h78}});
    reg_write_wb_even = 1'b0;
    @(negedge clk);
    check("fw_none_array", rc_even, {16{8'h78}});
    // invalid forwarding entry is ignored
    idle();
    wr_even(7'd50, {16{8'h55}});
    @(negedge clk);
    idle();
    fw_addr_wb_odd[1] = 7'd50; fw_wb_odd[1] = {16{8'hFF}};
    fw_write_wb_odd[0] = 1'b1; fw_addr_wb_odd[0] = 7'd50; fw_wb_odd[0] = {16{8'hEE}};
    ra_addr_odd = 7'd50;
    @(negedge clk);
    check("fw_invalid", ra_odd, {16{8'h55}});
    // address extremes
    idle();
    wr_even(7'd127, {16{8'hC3}});
    reg_write_wb_odd = 1'b1; rt_addr_wb_odd = 7'd0; rt_wb_odd = {16{8'h3C}};
    @(negedge clk);
    idle();
    ra_addr_even = 7'd127; rb_addr_even = 7'd0;
    @(negedge clk);
    check("r127", ra_even, {16{8'hC3}});
    check("r0", rb_even, {16{8'h3C}});
    // random traffic on a small address window, checked by the model each cycle
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      reg_write_wb_even = 1'($urandom_range(0, 1));
      reg_write_wb_odd = 1'($urandom_range(0, 1));
      rt_addr_wb_even = 7'($urandom_range(0, 7));
      rt_addr_wb_odd = 7'($urandom_range(0, 7));
      rt_wb_even = {$urandom, $urandom, $urandom, $urandom};
      rt_wb_odd = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 7; i++) begin
        fw_write_wb_even[i] = ($urandom_range(0, 3) == 0);
        fw_write_wb_odd[i] = ($urandom_range(0, 3) == 0);
        fw_addr_wb_even[i] = 7'($urandom_range(0, 7));
        fw_addr_wb_odd[i] = 7'($urandom_range(0, 7));
        fw_wb_even[i] = {$urandom, $urandom, $urandom, $urandom};
        fw_wb_odd[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      ra_addr_even = 7'($urandom_range(0, 7));
      rb_addr_even = 7'($urandom_range(0, 7));
      rc_addr_even = 7'($urandom_range(0, 7));
      ra_addr_odd = 7'($urandom_range(0, 7));
      rb_addr_odd = 7'($urandom_range(0, 7));
      rc_addr_odd = 7'($urandom_range(120, 127));
      @(negedge clk);
    end
    idle();
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
